// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: single-port memory arbiter and access sequencer.
// Fetch and data requesters share one fixed-latency memory, round-robin on ties.
module sisc_mem_arb #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          gnt_sel_q, gnt_sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic          busy_q, busy_d;
    logic          sel;

    // Next-state: arbitrate in IDLE, count down the access, pulse done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_sel_d  = gnt_sel_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        sel        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // Data wins when alone, or on a tie if fetch went last.
                    sel        = d_req && (!if_req || !last_gnt_q);
                    gnt_sel_d  = sel;
                    last_gnt_d = sel;
                    addr_d     = sel ? d_addr : if_addr;
                    we_d       = sel && d_we;
                    wdata_d    = sel ? d_wdata : '0;
                    cnt_d      = CNT_INIT;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (gnt_sel_q) d_rdata_d = mem_rdata;
                        else           if_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are flops decoded from the next state, so nothing is combinational.
    always_comb begin
        mem_en_d  = (state_d == ACCESS);
        mem_we_d  = (state_d == ACCESS) && we_d;
        if_done_d = (state_d == DONE) && !gnt_sel_d;
        d_done_d  = (state_d == DONE) && gnt_sel_d;
        busy_d    = (state_d != IDLE);
    end

    // State and capture registers; reset discards any in-flight access.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b0;
            gnt_sel_q  <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt_sel_q  <= gnt_sel_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule
